// File: rtl/ddram_clear.sv
// Memory-clear sequencer: fills a DDR3 region with a constant pattern using
// bounded, restartable, stall-aware Avalon burst writes.
module ddram_clear #(
    parameter int          BURST = 128,
    parameter logic [63:0] FILL  = 64'h0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [28:0] base_addr,
    input  logic [28:0] len,
    output logic        busy,
    output logic        done,
    output logic [28:0] words_done,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [28:0] BURST_W = 29'(BURST);
    localparam logic [7:0]  BURST_B = 8'(BURST);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [28:0] cur_addr_r;
    logic [28:0] remaining_r;
    logic [7:0]  beat_r;
    logic        abort_pend_r;
    logic        busy_r;
    logic        done_r;
    logic [28:0] words_done_r;
    logic        we_r;
    logic [7:0]  burstcnt_r;
    logic [28:0] addr_r;

    logic        take_start_s;
    logic        load_burst_s;
    logic        load_exit_s;
    logic        accept_s;
    logic        last_beat_s;
    logic [7:0]  n_s;

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_nxt_s  = state_r;
        take_start_s = 1'b0;
        load_burst_s = 1'b0;
        load_exit_s  = 1'b0;
        last_beat_s  = 1'b0;
        accept_s     = 1'b0;
        n_s          = (remaining_r < BURST_W) ? remaining_r[7:0] : BURST_B;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt_s  = S_LOAD;
                    take_start_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_LOAD: begin
                if (remaining_r == 29'd0) begin
                    state_nxt_s = S_DONE;
                    load_exit_s = 1'b1;
                end else if (abort_pend_r) begin
                    state_nxt_s = S_IDLE;
                    load_exit_s = 1'b1;
                end else begin
                    state_nxt_s  = S_WRITE;
                    load_burst_s = 1'b1;
                end
            end
            S_WRITE: begin
                accept_s = we_r & ~DDRAM_BUSY;
                if (accept_s && (beat_r == 8'd1)) begin
                    state_nxt_s = S_LOAD;
                    last_beat_s = 1'b1;
                end else begin
                    state_nxt_s = S_WRITE;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: address/length bookkeeping, burst launch and beat accounting
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_r   <= 29'd0;
            remaining_r  <= 29'd0;
            beat_r       <= 8'd0;
            abort_pend_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            words_done_r <= 29'd0;
            we_r         <= 1'b0;
            burstcnt_r   <= 8'd0;
            addr_r       <= 29'd0;
        end else begin
            if (take_start_s) begin
                cur_addr_r   <= base_addr;
                remaining_r  <= len;
                done_r       <= 1'b0;
                words_done_r <= 29'd0;
                abort_pend_r <= 1'b0;
                busy_r       <= 1'b1;
            end else if (load_exit_s) begin
                busy_r <= 1'b0;
                done_r <= (remaining_r == 29'd0);
            end else if (load_burst_s) begin
                addr_r       <= cur_addr_r;
                burstcnt_r   <= n_s;
                beat_r       <= n_s;
                we_r         <= 1'b1;
                abort_pend_r <= abort_pend_r | abort;
            end else if (state_r == S_WRITE) begin
                abort_pend_r <= abort_pend_r | abort;
                if (accept_s) begin
                    words_done_r <= words_done_r + 29'd1;
                    remaining_r  <= remaining_r - 29'd1;
                    beat_r       <= beat_r - 8'd1;
                end else begin
                    beat_r <= beat_r;
                end
                // Burst fully accepted: advance by its length, wrapping mod 2^29
                if (last_beat_s) begin
                    we_r       <= 1'b0;
                    cur_addr_r <= cur_addr_r + {21'd0, burstcnt_r};
                end else begin
                    we_r <= we_r;
                end
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign words_done     = words_done_r;
    assign DDRAM_BURSTCNT = burstcnt_r;
    assign DDRAM_ADDR     = addr_r;
    assign DDRAM_DIN      = FILL;
    assign DDRAM_BE       = 8'hFF;
    assign DDRAM_WE       = we_r;
    assign DDRAM_RD       = 1'b0;

endmodule

// File: doc/ddram_clear.md
Name: ddram_clear

Overview:
- Memory-clear sequencer on the clk_sys domain, directly upstream of the DDR3 port.
- Fills a programmable region of DDR3 with a constant 64-bit pattern using Avalon-style burst writes, so cores launched after the menu start with clean RAM.
- Replaces the free-running address/we counter with a bounded, restartable, stall-aware engine that reports progress and completion.

Parameters:
- BURST, 128: maximum beats per burst; integer, 1..255.
- FILL, 64'h0: data written on every beat.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE or DONE.
- abort  in  1  level; stops the operation after the current burst completes.
- base_addr  in  29  first 64-bit word address; latched on start.
- len  in  29  number of 64-bit words to write; latched on start.
- busy  out  1  high from the cycle after start until the return to IDLE or DONE.
- done  out  1  sticky; set on normal completion, cleared on start or reset.
- words_done  out  29  count of beats accepted so far.
- DDRAM_BUSY  in  1  waitrequest; a beat is accepted when DDRAM_WE & ~DDRAM_BUSY.
- DDRAM_BURSTCNT  out  8  beat count of the current burst.
- DDRAM_ADDR  out  29  start address of the current burst.
- DDRAM_DIN  out  64  write data; always FILL.
- DDRAM_BE  out  8  byte enables; always 8'hFF.
- DDRAM_WE  out  1  write request.
- DDRAM_RD  out  1  tied 0.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, busy=0, done=0, words_done=0, DDRAM_WE=0, DDRAM_BURSTCNT=0, DDRAM_ADDR=0.
- Internal registers:
  - cur_addr, remaining: 29 bits each.
  - beat: 8 bits, beats left in the current burst.
  - abort_pend: 1 bit.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE, start=1:
  - Latch base_addr into cur_addr and len into remaining.
  - Clear done, words_done and abort_pend.
  - Next state is LOAD; busy=1 from the next cycle.
- IDLE/DONE, start=0: hold.
- LOAD, remaining==0 or abort_pend=1: go to DONE if remaining==0, else IDLE. busy falls. No WE is issued.
- LOAD, otherwise:
  - n = min(BURST, remaining).
  - DDRAM_ADDR<=cur_addr, DDRAM_BURSTCNT<=n, beat<=n, DDRAM_WE<=1.
  - Next state is WRITE, so WE rises 2 cycles after start.
- WRITE, on each accepted beat:
  - words_done+1, remaining-1, beat-1.
  - ADDR, BURSTCNT and DIN are held constant for the whole burst.
- WRITE, on the last accepted beat (beat==1): WE<=0, cur_addr<=cur_addr+n, next state is LOAD.
  - Exactly one idle cycle separates bursts.
- WRITE, DDRAM_BUSY=1: the beat is not accepted; all outputs hold. Stalls are unbounded and there is no timeout.
- abort:
  - Sampled every cycle in LOAD/WRITE; sets abort_pend.
  - A started burst always completes its full BURSTCNT beats, as the protocol requires.
  - The next LOAD ends in IDLE with done=0; words_done keeps the partial count.
- start during LOAD/WRITE is ignored.
- start and abort in the same IDLE cycle: start is taken and abort is ignored.
- Arithmetic:
  - cur_addr wraps modulo 2^29 without error.
  - base_addr+len crossing 2^29 wraps silently.
  - remaining never underflows, because beats ≤ remaining by construction.
- reset_n low mid-burst drops WE immediately. This protocol violation is accepted only under reset; the DDR3 bridge is reset alongside.
- Invariant: at every return to IDLE or DONE, words_done equals the number of accepted beats.

Test Plan:
- base_addr=0x100, len=300, BURST=128, DDRAM_BUSY=0 → three bursts:
  - ADDR/BURSTCNT = 0x100/128, 0x180/128, 0x200/44.
  - 300 WE-high accept cycles and one gap cycle between bursts.
  - done=1 and words_done=300; busy falls on the same edge that done rises.
- Same run with DDRAM_BUSY high on every other cycle → still 300 accepted beats with identical addresses; ADDR, BURSTCNT and DIN are stable during stalls; total WE-high cycles ≈ 600.
- len=0, start pulse → busy high for 1 cycle (LOAD), no WE, then done=1 and words_done=0.
- len=300, abort pulse on the 10th beat of burst 1 → all 128 beats of burst 1 complete, no second burst, state IDLE, done=0, words_done=128.
- reset_n low on beat 50 of burst 1 → WE=0, busy=0, done=0, words_done=0 in the same cycle. After release, a start with len=4 writes one burst of BURSTCNT=4 at the new base_addr.
- base_addr=0x1FFFFFFE, len=4, BURST=2 → bursts at 0x1FFFFFFE then 0x00000000; done=1, words_done=4. A start pulse asserted during WRITE has no effect.
